// File: rtl/div8_seq_pkg.sv
// Shared constants and state encoding for the sequential 8-bit divider.
package div8_seq_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 3;
    localparam logic [7:0]  DZ_QUOT_DEF = 8'hFF;

    // 2'd3 is unused; the controller falls back to StIdle if it ever appears.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/sub8b.sv
// 8-bit ripple-borrow subtractor: {C_wy, D} = A - B - C_we, bit 1 is the LSB.
module sub8b (
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic A5,
    input  logic A6,
    input  logic A7,
    input  logic A8,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    input  logic B4,
    input  logic B5,
    input  logic B6,
    input  logic B7,
    input  logic B8,
    input  logic C_we,
    output logic D1,
    output logic D2,
    output logic D3,
    output logic D4,
    output logic D5,
    output logic D6,
    output logic D7,
    output logic D8,
    output logic C_wy
);

    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;

    assign a = {A8, A7, A6, A5, A4, A3, A2, A1};
    assign b = {B8, B7, B6, B5, B4, B3, B2, B1};

    // Ripple the borrow from LSB to MSB, one full-subtractor stage per bit.
    always_comb begin
        logic br;
        br = C_we;
        d  = '0;
        for (int i = 0; i < 8; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        C_wy = br;
    end

    assign {D8, D7, D6, D5, D4, D3, D2, D1} = d;

endmodule

// File: rtl/div8_seq.sv
// Sequential 8-bit unsigned restoring divider: one trial subtraction per cycle
// through a single sub8b, eight iterations per operation.
module div8_seq #(
    parameter int unsigned            WIDTH   = div8_seq_pkg::WIDTH,
    parameter logic [WIDTH-1:0]       DZ_QUOT = div8_seq_pkg::DZ_QUOT_DEF
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    import div8_seq_pkg::*;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   r_q, r_d;       // partial remainder
    logic [WIDTH-1:0]   q_q, q_d;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   d_q, d_d;       // captured divisor
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dz_q, dz_d;

    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   diff;
    logic               borrow;

    // Prefix of the dividend never reaches 2^WIDTH, so no extra remainder bit is needed.
    assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    sub8b u_sub (
        .A1   (shifted[0]),
        .A2   (shifted[1]),
        .A3   (shifted[2]),
        .A4   (shifted[3]),
        .A5   (shifted[4]),
        .A6   (shifted[5]),
        .A7   (shifted[6]),
        .A8   (shifted[7]),
        .B1   (d_q[0]),
        .B2   (d_q[1]),
        .B3   (d_q[2]),
        .B4   (d_q[3]),
        .B5   (d_q[4]),
        .B6   (d_q[5]),
        .B7   (d_q[6]),
        .B8   (d_q[7]),
        .C_we (1'b0),
        .D1   (diff[0]),
        .D2   (diff[1]),
        .D3   (diff[2]),
        .D4   (diff[3]),
        .D5   (diff[4]),
        .D6   (diff[5]),
        .D7   (diff[6]),
        .D8   (diff[7]),
        .C_wy (borrow)
    );

    // Next-state: accept in idle/done, iterate in run, publish results on the last step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = DZ_QUOT;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        q_d     = dividend;
                        d_d     = divisor;
                        r_d     = '0;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Borrow means the trial subtraction went negative: restore.
                r_d = borrow ? shifted : diff;
                q_d = {q_q[WIDTH-2:0], ~borrow};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quot_d  = q_d;
                    rem_d   = r_d;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule
